// File: rtl/vga_sprite_gen.sv
// vga_sprite_gen
//   Parametrised VGA raster generator with N overlaid circular sprites.
//   Sprite state is shadowed once per frame (on the last pixel of the
//   frame) so the game logic may update the inputs at any time without
//   tearing. All outputs are registered, one clock after the counters.
//
// Ports
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   obj_x / obj_y   packed sprite centres, object i at [i*XW +: XW] / [i*YW +: YW]
//   obj_en          per-sprite enable
//   obj_rgb         packed per-sprite colour {R,G,B}, object i at [i*12 +: 12]
//   bg_rgb          colour of active pixels not covered by any sprite
//   vgaRed/Green/Blue  pixel colour (0 outside the active area)
//   Hsync, Vsync    sync pulses, asserted level SYNC_POL
//   de              high for active-area pixels
//   pix_x, pix_y    coordinate of the pixel currently presented
//   frame_start     one-cycle pulse presented with pixel (0,0)
module vga_sprite_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 64,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 200,
    parameter int V_ACTIVE = 800,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 24,
    parameter bit SYNC_POL = 1'b1,
    parameter int N_OBJ    = 2,
    parameter int RADIUS   = 10,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_OBJ*XW-1:0]   obj_x,
    input  logic [N_OBJ*YW-1:0]   obj_y,
    input  logic [N_OBJ-1:0]      obj_en,
    input  logic [N_OBJ*12-1:0]   obj_rgb,
    input  logic [11:0]           bg_rgb,
    output logic [3:0]            vgaRed,
    output logic [3:0]            vgaGreen,
    output logic [3:0]            vgaBlue,
    output logic                  Hsync,
    output logic                  Vsync,
    output logic                  de,
    output logic [XW-1:0]         pix_x,
    output logic [YW-1:0]         pix_y,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // dx/dy are sign-extended to PW bits so the squares are exact; the sum
    // gets one extra bit (2*max(XW,YW)+3 in total).
    localparam int CW = ((XW > YW) ? XW : YW) + 1;
    localparam int PW = 2 * CW;
    localparam int SW = PW + 1;

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] R_SQ     = SW'(RADIUS * RADIUS);

    logic [XW-1:0]         r_h;
    logic [YW-1:0]         r_v;
    logic [N_OBJ*XW-1:0]   r_obj_x;
    logic [N_OBJ*YW-1:0]   r_obj_y;
    logic [N_OBJ-1:0]      r_obj_en;
    logic [N_OBJ*12-1:0]   r_obj_rgb;

    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_active;
    logic                  w_hs_on;
    logic                  w_vs_on;
    logic [N_OBJ-1:0]      w_hit;
    logic                  w_any;
    logic [11:0]           w_sel_rgb;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_active = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign w_hs_on  = (r_h >= HS_BEG) && (r_h < HS_END);
    assign w_vs_on  = (r_v >= VS_BEG) && (r_v < VS_END);

    // Raster counters and per-frame sprite shadow. The shadow load shares
    // the edge with the frame wrap, so pixel (0,0) already sees new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h       <= '0;
            r_v       <= '0;
            r_obj_x   <= '0;
            r_obj_y   <= '0;
            r_obj_en  <= '0;
            r_obj_rgb <= '0;
        end else begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
            if (w_h_last && w_v_last) begin
                r_obj_x   <= obj_x;
                r_obj_y   <= obj_y;
                r_obj_en  <= obj_en;
                r_obj_rgb <= obj_rgb;
            end
        end
    end

    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
        logic signed [XW:0]   w_dx;
        logic signed [YW:0]   w_dy;
        logic signed [PW-1:0] w_dxe;
        logic signed [PW-1:0] w_dye;
        logic signed [PW-1:0] w_dx2;
        logic signed [PW-1:0] w_dy2;
        logic [SW-1:0]        w_d2;

        assign w_dx  = $signed({1'b0, r_h}) - $signed({1'b0, r_obj_x[g*XW +: XW]});
        assign w_dy  = $signed({1'b0, r_v}) - $signed({1'b0, r_obj_y[g*YW +: YW]});
        assign w_dxe = PW'(w_dx);
        assign w_dye = PW'(w_dy);
        assign w_dx2 = w_dxe * w_dxe;
        assign w_dy2 = w_dye * w_dye;
        // Squares are non-negative, so add them as unsigned.
        assign w_d2  = {1'b0, w_dx2} + {1'b0, w_dy2};
        assign w_hit[g] = r_obj_en[g] && (w_d2 < R_SQ);
    end

    // Lowest-index hit sprite wins.
    always_comb begin
        w_any     = 1'b0;
        w_sel_rgb = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (w_hit[i] && !w_any) begin
                w_any     = 1'b1;
                w_sel_rgb = r_obj_rgb[i*12 +: 12];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {vgaRed, vgaGreen, vgaBlue} <= '0;
            Hsync       <= ~SYNC_POL;
            Vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            if (w_active)
                {vgaRed, vgaGreen, vgaBlue} <= w_any ? w_sel_rgb : bg_rgb;
            else
                {vgaRed, vgaGreen, vgaBlue} <= '0;
            Hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            Vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            de          <= w_active;
            pix_x       <= r_h;
            pix_y       <= r_v;
            frame_start <= (r_h == '0) && (r_v == '0);
        end
    end

endmodule

// File: tb/tb_vga_sprite_gen.sv
module tb_vga_sprite_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [21:0] obj_x;
    logic [19:0] obj_y;
    logic [1:0]  obj_en;
    logic [23:0] obj_rgb;
    logic [11:0] bg_rgb;

    // default-timing instance
    logic [3:0]  d_r, d_g, d_b;
    logic        d_hs, d_vs, d_de, d_fs;
    logic [10:0] d_px;
    logic [9:0]  d_py;
    // mid-size instance: 80-clk lines, 54-line frames
    logic [3:0]  m_r, m_g, m_b;
    logic        m_hs, m_vs, m_de, m_fs;
    logic [10:0] m_px;
    logic [9:0]  m_py;
    // tiny instance: 14-clk lines, 7-line frames, active-low syncs
    logic [3:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_de, s_fs;
    logic [10:0] s_px;
    logic [9:0]  s_py;

    logic [11:0] d_col, m_col;
    assign d_col = {d_r, d_g, d_b};
    assign m_col = {m_r, m_g, m_b};

    localparam int MID_FRAME = 80 * 54;
    localparam int SML_FRAME = 14 * 7;

    vga_sprite_gen u_def (
        .clk(clk), .rst_n(rst_n), .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en),
        .obj_rgb(obj_rgb), .bg_rgb(bg_rgb), .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b),
        .Hsync(d_hs), .Vsync(d_vs), .de(d_de), .pix_x(d_px), .pix_y(d_py), .frame_start(d_fs)
    );

    vga_sprite_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(1), .V_SYNC(3), .V_BP(2)
    ) u_mid (
        .clk(clk), .rst_n(rst_n), .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en),
        .obj_rgb(obj_rgb), .bg_rgb(bg_rgb), .vgaRed(m_r), .vgaGreen(m_g), .vgaBlue(m_b),
        .Hsync(m_hs), .Vsync(m_vs), .de(m_de), .pix_x(m_px), .pix_y(m_py), .frame_start(m_fs)
    );

    vga_sprite_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en),
        .obj_rgb(obj_rgb), .bg_rgb(bg_rgb), .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b),
        .Hsync(s_hs), .Vsync(s_vs), .de(s_de), .pix_x(s_px), .pix_y(s_py), .frame_start(s_fs)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          sc_cnt, sc_de, sc_hs, sc_vs, sc_fs, sc_hs_x0, sc_vs_y0;
    logic [11:0] sc_p1, sc_p2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mid_fs();
        int k = 0;
        while (!m_fs && k < 5000) begin
            tick();
            k++;
        end
        check("mid_fs_seen", 32'(m_fs), 32'd1);
    endtask

    // Walks one whole mid-instance frame starting at its frame_start sample.
    task automatic scan_mid(input logic [11:0] col, input int p1x, input int p1y,
                            input int p2x, input int p2y, input int chg_idx,
                            input logic [10:0] chg_x);
        sc_cnt = 0; sc_de = 0; sc_hs = 0; sc_vs = 0; sc_fs = 0;
        sc_hs_x0 = -1; sc_vs_y0 = -1;
        sc_p1 = 12'hEEE; sc_p2 = 12'hEEE;
        for (int i = 0; i < MID_FRAME; i++) begin
            if (m_col == col) sc_cnt++;
            if (m_de) sc_de++;
            if (m_hs) begin
                sc_hs++;
                if (m_py == 10'd0 && sc_hs_x0 < 0) sc_hs_x0 = int'(m_px);
            end
            if (m_vs) begin
                sc_vs++;
                if (sc_vs_y0 < 0) sc_vs_y0 = int'(m_py);
            end
            if (m_fs) sc_fs++;
            if (int'(m_px) == p1x && int'(m_py) == p1y) sc_p1 = m_col;
            if (int'(m_px) == p2x && int'(m_py) == p2y) sc_p2 = m_col;
            if (i == chg_idx) obj_x[10:0] = chg_x;
            tick();
        end
    endtask

    initial begin
        int hs_x0, hs_cnt, de_cnt, fs_cnt, vs_y0, vs_cnt, k;

        rst_n   = 1'b0;
        obj_x   = {11'd0, 11'd32};
        obj_y   = {10'd0, 10'd24};
        obj_en  = 2'b01;
        obj_rgb = {12'h000, 12'hF00};
        bg_rgb  = 12'hFFF;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (300) tick();

        // Asynchronous reset in the middle of a line.
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pix_x", 32'(d_px), 32'd0);
        check("rst_async_de", 32'(d_de), 32'd0);
        check("rst_async_col", 32'(d_col), 32'd0);
        check("rst_async_hsync_pos", 32'(d_hs), 32'd0);
        check("rst_async_hsync_neg", 32'(s_hs), 32'd1);
        check("rst_async_vsync_neg", 32'(s_vs), 32'd1);
        repeat (5) tick();
        check("rst_hold_pix_x", 32'(m_px), 32'd0);
        check("rst_hold_fs", 32'(d_fs), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_fs", 32'(d_fs), 32'd1);
        check("post_rst_pix", {d_py, 11'd0, d_px}, 32'd0);
        check("post_rst_de", 32'(d_de), 32'd1);
        check("post_rst_bg", 32'(d_col), 32'hFFF);
        check("post_rst_mid_fs", 32'(m_fs), 32'd1);

        // One default-timing line.
        hs_x0 = -1; hs_cnt = 0; de_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 1680; i++) begin
            if (d_hs) begin
                hs_cnt++;
                if (hs_x0 < 0) hs_x0 = int'(d_px);
            end
            if (d_de) de_cnt++;
            if (d_fs) fs_cnt++;
            tick();
        end
        check("def_hsync_start", 32'(hs_x0), 32'd1344);
        check("def_hsync_width", 32'(hs_cnt), 32'd136);
        check("def_de_per_line", 32'(de_cnt), 32'd1280);
        check("def_fs_once", 32'(fs_cnt), 32'd1);
        check("def_line_wrap", {d_py, 11'd0, d_px}, {10'd1, 11'd0, 11'd0});

        // First frame after reset: sprites disabled although obj_en=1.
        k = 0;
        while (!(m_px == 11'd32 && m_py == 10'd24) && k < 5000) begin
            tick();
            k++;
        end
        check("first_frame_sprite_off", 32'(m_col), 32'hFFF);

        // F1: single sprite at (32,24).
        wait_mid_fs();
        scan_mid(12'hF00, 42, 24, 41, 24, -1, 11'd0);
        check("single_count", 32'(sc_cnt), 32'd305);
        check("single_r_edge_bg", 32'(sc_p1), 32'hFFF);
        check("single_r_edge_in", 32'(sc_p2), 32'hF00);
        check("mid_de_count", 32'(sc_de), 32'd3072);
        check("mid_hs_count", 32'(sc_hs), 32'd432);
        check("mid_hs_start", 32'(sc_hs_x0), 32'd68);
        check("mid_vs_count", 32'(sc_vs), 32'd240);
        check("mid_vs_first_line", 32'(sc_vs_y0), 32'd49);
        check("mid_fs_once", 32'(sc_fs), 32'd1);
        check("mid_frame_period", 32'(m_fs), 32'd1);

        // Change inputs mid-frame: this frame must keep the old sprite.
        obj_x   = {11'd25, 11'd20};
        obj_y   = {10'd20, 10'd20};
        obj_en  = 2'b11;
        obj_rgb = {12'h00F, 12'h0F0};
        scan_mid(12'hF00, 32, 24, 0, 0, -1, 11'd0);
        check("held_shadow_count", 32'(sc_cnt), 32'd305);

        // F3: overlap, lower index wins.
        scan_mid(12'h0F0, 23, 20, 32, 20, -1, 11'd0);
        check("overlap_s0_wins", 32'(sc_p1), 32'h0F0);
        check("overlap_s1_only", 32'(sc_p2), 32'h00F);
        check("overlap_s0_count", 32'(sc_cnt), 32'd305);

        obj_x   = {11'd0, 11'd20};
        obj_y   = {10'd0, 10'd30};
        obj_en  = 2'b01;
        obj_rgb = {12'h000, 12'hF00};
        scan_mid(12'hF00, 0, 0, 0, 0, -1, 11'd0);
        check("still_overlap_no_red", 32'(sc_cnt), 32'd0);

        // F5: obj_x moves 20 -> 40 at row 30 while the sprite is being drawn.
        scan_mid(12'hF00, 20, 35, 40, 35, 30 * 80, 11'd40);
        check("midupd_old_pos", 32'(sc_p1), 32'hF00);
        check("midupd_new_pos_bg", 32'(sc_p2), 32'hFFF);
        check("midupd_count", 32'(sc_cnt), 32'd305);
        scan_mid(12'hF00, 40, 35, 20, 35, -1, 11'd0);
        check("nextfr_new_pos", 32'(sc_p1), 32'hF00);
        check("nextfr_old_pos_bg", 32'(sc_p2), 32'hFFF);

        // Corner sprite at (0,0): quadrant of dx,dy >= 0 with dx^2+dy^2 < 100.
        obj_x[10:0] = 11'd0;
        obj_y[9:0]  = 10'd0;
        scan_mid(12'hF00, 0, 0, 0, 0, -1, 11'd0);
        check("corner_prev_frame", 32'(sc_cnt), 32'd305);
        scan_mid(12'hF00, 0, 0, 70, 10, -1, 11'd0);
        check("corner_count", 32'(sc_cnt), 32'd86);
        check("corner_origin", 32'(sc_p1), 32'hF00);
        check("blank_black", 32'(sc_p2), 32'h000);

        // Tiny instance, active-low syncs.
        k = 0;
        while (!s_fs && k < 200) begin
            tick();
            k++;
        end
        check("sml_fs_seen", 32'(s_fs), 32'd1);
        hs_x0 = -1; hs_cnt = 0; vs_y0 = -1; vs_cnt = 0; de_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < SML_FRAME; i++) begin
            if (!s_hs) begin
                hs_cnt++;
                if (s_py == 10'd0 && hs_x0 < 0) hs_x0 = int'(s_px);
            end
            if (!s_vs) begin
                vs_cnt++;
                if (vs_y0 < 0) vs_y0 = int'(s_py);
            end
            if (s_de) de_cnt++;
            if (s_fs) fs_cnt++;
            tick();
        end
        check("sml_hs_low_start", 32'(hs_x0), 32'd10);
        check("sml_hs_low_count", 32'(hs_cnt), 32'd14);
        check("sml_vs_low_line", 32'(vs_y0), 32'd5);
        check("sml_vs_low_count", 32'(vs_cnt), 32'd14);
        check("sml_de_count", 32'(de_cnt), 32'd32);
        check("sml_fs_once", 32'(fs_cnt), 32'd1);
        check("sml_frame_period", 32'(s_fs), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
